// File: rtl/banked_register_file.sv
// Banked ARM register file with NUM_READ combinational read ports, two write ports with bypass,
// an auto-advancing PC in the top register, and a per-register busy scoreboard.
module banked_register_file #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 3,
  parameter int PC_INCR    = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_addr,
  output logic [NUM_READ*WORD_SIZE-1:0]    read_data,
  output logic [NUM_READ-1:0]              read_busy,
  input  logic                             wr_en_a,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_a,
  input  logic [WORD_SIZE-1:0]             wr_data_a,
  input  logic                             wr_en_b,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_b,
  input  logic [WORD_SIZE-1:0]             wr_data_b,
  input  logic                             pc_advance,
  input  logic                             sb_set_en,
  input  logic [ADDR_WIDTH-1:0]            sb_set_addr,
  output logic [WORD_SIZE-1:0]             pc_out,
  output logic [NUM_REGS-1:0]              busy_out
);

  localparam logic [ADDR_WIDTH-1:0] PC_ADDR     = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [WORD_SIZE-1:0]  PC_STEP     = WORD_SIZE'(PC_INCR);
  localparam logic [WORD_SIZE-1:0]  PC_READ_OFS = WORD_SIZE'(2 * PC_INCR);

  logic [WORD_SIZE-1:0] gpr_q [NUM_REGS-1];
  logic [WORD_SIZE-1:0] pc_q;
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  // The PC reads two instructions ahead of the fetch address, matching the ARM pipeline.
  function automatic logic [WORD_SIZE-1:0] pc_view(input logic [WORD_SIZE-1:0] pc);
    return pc + PC_READ_OFS;
  endfunction

  function automatic logic addr_hit(input logic                  en,
                                    input logic [ADDR_WIDTH-1:0] wa,
                                    input logic [ADDR_WIDTH-1:0] ra);
    return en && (wa == ra);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS - 1; r++) gpr_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS - 1; r++) begin
        if (addr_hit(wr_en_a, wr_addr_a, ADDR_WIDTH'(r)))
          gpr_q[r] <= wr_data_a;
        else if (addr_hit(wr_en_b, wr_addr_b, ADDR_WIDTH'(r)))
          gpr_q[r] <= wr_data_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      pc_q <= '0;
    else if (addr_hit(wr_en_a, wr_addr_a, PC_ADDR))
      pc_q <= wr_data_a;
    else if (addr_hit(wr_en_b, wr_addr_b, PC_ADDR))
      pc_q <= wr_data_b;
    else if (pc_advance)
      pc_q <= pc_q + PC_STEP;
  end

  // A new issue to a register outranks a writeback retiring the previous producer.
  always_comb begin
    busy_d = '0;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      if (addr_hit(sb_set_en, sb_set_addr, ADDR_WIDTH'(r)))
        busy_d[r] = 1'b1;
      else if (addr_hit(wr_en_a, wr_addr_a, ADDR_WIDTH'(r)) ||
               addr_hit(wr_en_b, wr_addr_b, ADDR_WIDTH'(r)))
        busy_d[r] = 1'b0;
      else
        busy_d[r] = busy_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  always_comb begin : read_ports
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit_a;
    logic                  hit_b;
    read_data = '0;
    read_busy = '0;
    ra        = '0;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra    = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      hit_a = addr_hit(wr_en_a, wr_addr_a, ra);
      hit_b = addr_hit(wr_en_b, wr_addr_b, ra);
      if (ra == PC_ADDR)
        read_data[i*WORD_SIZE +: WORD_SIZE] = pc_view(pc_q);
      else if (hit_a)
        read_data[i*WORD_SIZE +: WORD_SIZE] = wr_data_a;
      else if (hit_b)
        read_data[i*WORD_SIZE +: WORD_SIZE] = wr_data_b;
      else if (ra < PC_ADDR)
        read_data[i*WORD_SIZE +: WORD_SIZE] = gpr_q[ra];
      read_busy[i] = (ra < PC_ADDR) && busy_q[ra] && !(hit_a || hit_b);
    end
  end

  assign pc_out   = pc_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_banked_register_file.sv
// Table-driven bench for banked_register_file: combinational reads checked before each edge,
// registered pc_out/busy_out expectations queued and compared after the edge.
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] read_addr;
  logic [95:0] read_data;
  logic [2:0]  read_busy;
  logic        wr_en_a, wr_en_b, pc_advance, sb_set_en;
  logic [3:0]  wr_addr_a, wr_addr_b, sb_set_addr;
  logic [31:0] wr_data_a, wr_data_b, pc_out;
  logic [15:0] busy_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rn;
    logic        ae;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        be;
    logic [3:0]  ba;
    logic [31:0] bd;
    logic        adv;
    logic        se;
    logic [3:0]  sa;
    logic [3:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  eb;
    logic [31:0] epc;
    logic [15:0] ebusy;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [15:0] busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  banked_register_file dut (
    .clk(clk), .reset_n(reset_n), .read_addr(read_addr), .read_data(read_data),
    .read_busy(read_busy), .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .pc_advance(pc_advance),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pc_out(pc_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(string n, logic rn, logic ae, logic [3:0] aa, logic [31:0] ad,
                             logic be, logic [3:0] ba, logic [31:0] bd, logic adv,
                             logic se, logic [3:0] sa, logic [3:0] r0, logic [3:0] r1,
                             logic [3:0] r2, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2,
                             logic [2:0] eb, logic [31:0] epc, logic [15:0] ebusy);
    vec_t t;
    t.name = n; t.rn = rn; t.ae = ae; t.aa = aa; t.ad = ad; t.be = be; t.ba = ba; t.bd = bd;
    t.adv = adv; t.se = se; t.sa = sa; t.ra0 = r0; t.ra1 = r1; t.ra2 = r2;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.eb = eb; t.epc = epc; t.ebusy = ebusy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic apply(input vec_t t);
    exp_t e;
    reset_n     = t.rn;
    wr_en_a     = t.ae; wr_addr_a = t.aa; wr_data_a = t.ad;
    wr_en_b     = t.be; wr_addr_b = t.ba; wr_data_b = t.bd;
    pc_advance  = t.adv;
    sb_set_en   = t.se; sb_set_addr = t.sa;
    read_addr   = {t.ra2, t.ra1, t.ra0};
    #4;
    chk({t.name, ".rd0"}, read_data[31:0],  t.e0);
    chk({t.name, ".rd1"}, read_data[63:32], t.e1);
    chk({t.name, ".rd2"}, read_data[95:64], t.e2);
    chk({t.name, ".rbusy"}, {29'd0, read_busy}, {29'd0, t.eb});
    e.name = t.name; e.pc = t.epc; e.busy = t.ebusy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s.queue: got empty expected entry", t.name);
    end else begin
      e = sb_q.pop_front();
      chk({e.name, ".pc_out"}, pc_out, e.pc);
      chk({e.name, ".busy_out"}, {16'd0, busy_out}, {16'd0, e.busy});
    end
  endtask

  initial begin
    vec_t t;
    reset_n = 1'b0; wr_en_a = 0; wr_en_b = 0; pc_advance = 0; sb_set_en = 0;
    wr_addr_a = 0; wr_addr_b = 0; sb_set_addr = 0; wr_data_a = 0; wr_data_b = 0;
    read_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Preload every register (PC included) to all-ones and mark r0..r7 busy.
    for (int k = 0; k < 8; k++) begin
      t = v($sformatf("preload%0d", k), 1, 1, 4'(2*k), 32'hFFFF_FFFF, 1, 4'(2*k+1),
            32'hFFFF_FFFF, 0, 1, 4'(k), 4'(2*k), 4'(2*k+1), 4'd0,
            32'hFFFF_FFFF, (k == 7) ? 32'h8 : 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            (k > 0) ? 3'b100 : 3'b000, (k == 7) ? 32'hFFFF_FFFF : 32'h0,
            16'((1 << (k+1)) - 1));
      apply(t);
    end

    // Reset overrides a concurrent write, advance and set.
    apply(v("reset_override", 0, 1, 4'd3, 32'h1234, 0, 4'd0, 0, 1, 1, 4'd5,
            4'd3, 4'd15, 4'd4, 32'h1234, 32'h7, 32'hFFFF_FFFF, 3'b100, 32'h0, 16'h0));
    for (int g = 0; g < 5; g++)
      apply(v($sformatf("post_reset%0d", g), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              4'(3*g), 4'(3*g+1), 4'(3*g+2), 0, 0, 0, 3'b000, 32'h0, 16'h0));

    tbl.push_back(v("ab_conflict", 1, 1, 4'd2, 32'h1234, 1, 4'd2, 32'h5678, 0, 0, 0,
                    4'd2, 4'd15, 4'd2, 32'h1234, 32'h8, 32'h1234, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("ab_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    4'd2, 4'd2, 4'd15, 32'h1234, 32'h1234, 32'h8, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("byp_setup", 1, 1, 4'd5, 32'hA, 0, 0, 0, 0, 0, 0,
                    4'd5, 4'd5, 4'd5, 32'hA, 32'hA, 32'hA, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("byp_three", 1, 1, 4'd5, 32'hB, 0, 0, 0, 0, 0, 0,
                    4'd5, 4'd5, 4'd5, 32'hB, 32'hB, 32'hB, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("byp_b", 1, 0, 0, 0, 1, 4'd6, 32'hC, 0, 0, 0,
                    4'd6, 4'd5, 4'd6, 32'hC, 32'hB, 32'hC, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("pc_wr_b", 1, 0, 0, 0, 1, 4'd15, 32'hFFFF_FFFC, 0, 0, 0,
                    4'd15, 4'd2, 4'd5, 32'h8, 32'h1234, 32'hB, 3'b000, 32'hFFFF_FFFC, 16'h0));
    tbl.push_back(v("pc_wrap", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                    4'd15, 4'd6, 4'd2, 32'h4, 32'hC, 32'h1234, 3'b000, 32'h0, 16'h0));
    tbl.push_back(v("pc_a_over_adv", 1, 1, 4'd15, 32'h100, 0, 0, 0, 1, 0, 0,
                    4'd15, 4'd15, 4'd15, 32'h8, 32'h8, 32'h8, 3'b000, 32'h100, 16'h0));
    tbl.push_back(v("pc_a_over_b", 1, 1, 4'd15, 32'h300, 1, 4'd15, 32'h200, 1, 0, 0,
                    4'd15, 4'd5, 4'd6, 32'h108, 32'hB, 32'hC, 3'b000, 32'h300, 16'h0));
    tbl.push_back(v("pc_adv", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                    4'd15, 4'd15, 4'd2, 32'h308, 32'h308, 32'h1234, 3'b000, 32'h304, 16'h0));
    tbl.push_back(v("pc_b_over_adv", 1, 0, 0, 0, 1, 4'd15, 32'h40, 1, 0, 0,
                    4'd15, 4'd6, 4'd5, 32'h30C, 32'hC, 32'hB, 3'b000, 32'h40, 16'h0));
    tbl.push_back(v("sb_set7", 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd7,
                    4'd7, 4'd7, 4'd15, 32'h0, 32'h0, 32'h48, 3'b000, 32'h40, 16'h0080));
    tbl.push_back(v("sb_busy7", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    4'd7, 4'd7, 4'd7, 32'h0, 32'h0, 32'h0, 3'b111, 32'h40, 16'h0080));
    tbl.push_back(v("sb_set_wins", 1, 1, 4'd7, 32'h77, 0, 0, 0, 0, 1, 4'd7,
                    4'd7, 4'd7, 4'd7, 32'h77, 32'h77, 32'h77, 3'b000, 32'h40, 16'h0080));
    tbl.push_back(v("sb_clear", 1, 0, 0, 0, 1, 4'd7, 32'h78, 0, 0, 0,
                    4'd7, 4'd7, 4'd7, 32'h78, 32'h78, 32'h78, 3'b000, 32'h40, 16'h0));
    tbl.push_back(v("sb_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    4'd7, 4'd7, 4'd7, 32'h78, 32'h78, 32'h78, 3'b000, 32'h40, 16'h0));
    tbl.push_back(v("sb_pc_ignored", 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd15,
                    4'd15, 4'd7, 4'd15, 32'h48, 32'h78, 32'h48, 3'b000, 32'h40, 16'h0));
    tbl.push_back(v("sb_pc_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    4'd15, 4'd15, 4'd15, 32'h48, 32'h48, 32'h48, 3'b000, 32'h40, 16'h0));
    tbl.push_back(v("sb_set9", 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd9,
                    4'd9, 4'd10, 4'd7, 32'h0, 32'h0, 32'h78, 3'b000, 32'h40, 16'h0200));
    tbl.push_back(v("sb_other_wr", 1, 1, 4'd10, 32'hAA, 0, 0, 0, 0, 0, 0,
                    4'd9, 4'd10, 4'd7, 32'h0, 32'hAA, 32'h78, 3'b001, 32'h40, 16'h0200));
    tbl.push_back(v("sb_b_clear", 1, 0, 0, 0, 1, 4'd9, 32'h99, 0, 1, 4'd10,
                    4'd9, 4'd10, 4'd9, 32'h99, 32'hAA, 32'h99, 3'b000, 32'h40, 16'h0400));
    tbl.push_back(v("sb_final", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    4'd10, 4'd9, 4'd0, 32'hAA, 32'h99, 32'h0, 3'b001, 32'h40, 16'h0400));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
# banked_register_file

Parametrised successor to the single-write, two-read register file for the ARM core. It provides NUM_READ combinational read ports and two write ports, with same-cycle write-to-read bypass. It also holds a dedicated program counter in the top register that auto-advances and reads back as PC + 2*PC_INCR (ARM pipeline semantics). A per-register busy scoreboard lets the issue stage stall on pending writes; the block sits between decode/issue and the writeback stage.

## Interface
- WORD_SIZE, 32, data width in bits
- NUM_REGS, 16, architectural registers; register NUM_REGS-1 is the PC
- ADDR_WIDTH, 4, register address width; must equal clog2(NUM_REGS)
- NUM_READ, 3, number of read ports (1..4)
- PC_INCR, 4, PC increment per pc_advance, in bytes
- clk  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk
- read_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  output  NUM_READ*WORD_SIZE  packed read data, combinational
- read_busy  output  NUM_READ  port i's register has a pending write that does not commit this cycle
- wr_en_a / wr_addr_a / wr_data_a  input  1 / ADDR_WIDTH / WORD_SIZE  write port A (ALU result); highest priority
- wr_en_b / wr_addr_b / wr_data_b  input  1 / ADDR_WIDTH / WORD_SIZE  write port B (load/store base writeback)
- pc_advance  input  1  increment the PC by PC_INCR this cycle
- sb_set_en / sb_set_addr  input  1 / ADDR_WIDTH  mark a register busy (instruction issued with that destination)
- pc_out  output  WORD_SIZE  current registered PC (fetch address)
- busy_out  output  NUM_REGS  scoreboard vector, registered

## Operation
- Reset (reset_n=0 at a rising edge): all GPRs, the PC and busy_out go to 0. Reset overrides every simultaneous write, advance or set.
- GPR write: on the rising edge, if wr_en_a is high, reg[wr_addr_a] <= wr_data_a. Port B behaves the same way. If both ports target the same address, port A wins and port B is dropped.
- PC update priority, highest first:
  - write from port A to NUM_REGS-1
  - write from port B to NUM_REGS-1
  - pc_advance, which sets pc <= pc + PC_INCR modulo 2^WORD_SIZE, wrapping silently
  - otherwise the PC holds its value
- GPR read, port i, address r != NUM_REGS-1: returns the winning write data if a write to r is enabled this cycle (bypass; A before B). Otherwise returns reg[r].
- PC read (r = NUM_REGS-1): returns pc_q + 2*PC_INCR modulo 2^WORD_SIZE. There is no bypass on the PC; a same-cycle PC write is seen next cycle.
- Scoreboard, per register r, each rising edge:
  - busy[r] sets when sb_set_en=1 and sb_set_addr=r
  - otherwise busy[r] clears when any enabled write targets r
  - otherwise busy[r] holds
  - If a set and a clear hit the same r in the same cycle, set wins: a new producer has issued.
- busy[NUM_REGS-1] is hard-wired 0; sb_set_en to the PC is ignored.
- read_busy[i] = busy[addr_i] AND NOT (an enabled write to addr_i this cycle). It is always 0 for the PC.

## Timing
- Reads and read_busy are combinational from read_addr, the write ports and registered state; zero latency.
- Writes, the PC update and scoreboard updates all take one cycle and are visible to reads after the next rising edge.
- Bypass makes write data visible in the same cycle for GPRs.
- pc_out is registered: after reset deasserts it is 0, and it is 4 after one pc_advance cycle (PC_INCR=4).
- There is no handshake; every input is sampled every cycle. X on a write address while its enable is low is don't-care.

## Test plan
- Reset with all registers preloaded to 0xFFFFFFFF, with wr_en_a=1 to r3 in the same cycle -> next cycle every read returns 0, busy_out=0, pc_out=0; reading r15 returns 0x8.
- wr_en_a to r2 with 0x1234 and wr_en_b to r2 with 0x5678 in one cycle, read port 0 on r2 -> same-cycle read_data=0x1234; the next cycle still reads 0x1234.
- Bypass: r5=0xA, then write 0xB to r5 while ports 0..2 read r5 -> all three ports return 0xB in that cycle.
- PC: set pc to 0xFFFFFFFC via port B, then pc_advance for one cycle -> pc_out=0x0 (wrap). In the same cycle as an advance, write 0x100 via port A -> pc_out=0x100, not 0x104.
- Scoreboard: sb_set r7, and the next cycle reads r7 -> read_busy=1. A write to r7 with a concurrent sb_set r7 -> busy stays 1. A write to r7 alone -> read_busy=0 in the write cycle, and busy_out[7]=0 after the edge.
- sb_set_en to r15 -> busy_out[15] stays 0; reading r15 gives read_busy=0.
